// File: rtl/line_buffer_feeder.sv
// Raster pixel feeder: reads an IMG_W x IMG_H frame from a synchronous-read
// pixel memory and streams it into a line buffer write port with HBLANK idle
// cycles between lines. Fixed two-cycle read-to-write pipeline.
module line_buffer_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 2,
  parameter int HBLANK = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              we_o,
  output logic [DATA_W-1:0] data_o,
  output logic              line_end_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    BLANK,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [BLK_W-1:0] blk;
  logic             drain_cnt;
  logic             rd_d1;
  logic             le_d1;
  logic             last_col;

  // Current read is the last pixel of its line.
  always_comb begin
    last_col = (col == COL_LAST);
  end

  // Frame sequencer with registered outputs and the two-stage write pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      blk          <= '0;
      drain_cnt    <= 1'b0;
      rd_d1        <= 1'b0;
      le_d1        <= 1'b0;
      mem_rd_o     <= 1'b0;
      mem_addr_o   <= '0;
      we_o         <= 1'b0;
      data_o       <= '0;
      line_end_o   <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // Pipeline: read strobe -> data capture -> write strobe.
      rd_d1        <= mem_rd_o;
      le_d1        <= mem_rd_o && last_col;
      we_o         <= rd_d1;
      line_end_o   <= le_d1;
      frame_done_o <= 1'b0;
      if (rd_d1) begin
        data_o <= mem_data_i;
      end

      if (abort_i) begin
        // Flush in-flight reads so nothing reaches the line buffer after abort.
        state      <= IDLE;
        mem_rd_o   <= 1'b0;
        busy_o     <= 1'b0;
        rd_d1      <= 1'b0;
        le_d1      <= 1'b0;
        we_o       <= 1'b0;
        line_end_o <= 1'b0;
        col        <= '0;
        row        <= '0;
        blk        <= '0;
        drain_cnt  <= 1'b0;
        mem_addr_o <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state      <= READ;
              mem_rd_o   <= 1'b1;
              busy_o     <= 1'b1;
              col        <= '0;
              row        <= '0;
              mem_addr_o <= '0;
            end
          end
          READ: begin
            mem_addr_o <= mem_addr_o + ADDR_W'(1);
            if (last_col) begin
              col <= '0;
              if (row == ROW_LAST) begin
                state      <= DRAIN;
                mem_rd_o   <= 1'b0;
                drain_cnt  <= 1'b0;
                mem_addr_o <= '0;
              end else begin
                row <= row + ROW_W'(1);
                if (HBLANK > 0) begin
                  state    <= BLANK;
                  mem_rd_o <= 1'b0;
                  blk      <= '0;
                end
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
          BLANK: begin
            if (blk == BLK_LAST) begin
              state    <= READ;
              mem_rd_o <= 1'b1;
            end else begin
              blk <= blk + BLK_W'(1);
            end
          end
          DRAIN: begin
            if (drain_cnt) begin
              state        <= DONE;
              frame_done_o <= 1'b1;
            end else begin
              drain_cnt <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            mem_rd_o <= 1'b0;
            busy_o   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Directed bench for line_buffer_feeder: one instance with HBLANK=2 and one
// with HBLANK=0, each fed by a 1-cycle-latency memory holding mem[a]=a+1.
module tb_line_buffer_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;

  logic       rd0, we0, le0, fd0, busy0;
  logic [7:0] addr0, md0, d0;
  logic       rd1, we1, le1, fd1, busy1;
  logic [7:0] addr1, md1, d1;

  int tests = 0;
  int fails = 0;
  int n = 0;

  always #5 clk = ~clk;

  line_buffer_feeder #(.DATA_W(8), .IMG_W(10), .IMG_H(2), .HBLANK(2), .ADDR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .mem_rd_o(rd0), .mem_addr_o(addr0), .mem_data_i(md0),
    .we_o(we0), .data_o(d0), .line_end_o(le0), .frame_done_o(fd0), .busy_o(busy0)
  );

  line_buffer_feeder #(.DATA_W(8), .IMG_W(10), .IMG_H(2), .HBLANK(0), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .mem_rd_o(rd1), .mem_addr_o(addr1), .mem_data_i(md1),
    .we_o(we1), .data_o(d1), .line_end_o(le1), .frame_done_o(fd1), .busy_o(busy1)
  );

  // Synchronous-read memory models, mem[a] = a+1.
  always @(posedge clk) begin
    if (rd0) md0 <= addr0 + 8'd1;
    if (rd1) md1 <= addr1 + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Expected outputs for cycle n of a frame started at n=0 (start sampled at edge T).
  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      int hb, per, s, m;
      logic erd, ewe, ele, efd, ebusy;
      logic [7:0] eaddr, edat;
      logic ord, owe, ole, ofd, obusy;
      logic [7:0] oaddr, odat;
      hb = (d == 0) ? 2 : 0;
      per = 10 + hb;
      erd = 1'b0; ewe = 1'b0; ele = 1'b0; eaddr = '0; edat = '0;
      for (int r = 0; r < 2; r++) begin
        s = 1 + r * per;
        if (n >= s && n < s + 10) begin
          erd = 1'b1;
          eaddr = 8'(r * 10 + n - s);
        end
        m = n - 2;
        if (m >= s && m < s + 10) begin
          ewe = 1'b1;
          edat = 8'(r * 10 + m - s + 1);
          ele = ((m - s) == 9);
        end
      end
      efd = (n == per + 13);
      ebusy = (n >= 1 && n <= per + 13);
      ord = d ? rd1 : rd0;       oaddr = d ? addr1 : addr0;
      owe = d ? we1 : we0;       odat = d ? d1 : d0;
      ole = d ? le1 : le0;       ofd = d ? fd1 : fd0;
      obusy = d ? busy1 : busy0;
      chk($sformatf("mem_rd[%0d]", d), 32'(ord), 32'(erd));
      if (erd) chk($sformatf("mem_addr[%0d]", d), 32'(oaddr), 32'(eaddr));
      chk($sformatf("we[%0d]", d), 32'(owe), 32'(ewe));
      if (ewe) chk($sformatf("data[%0d]", d), 32'(odat), 32'(edat));
      chk($sformatf("line_end[%0d]", d), 32'(ole), 32'(ele));
      chk($sformatf("frame_done[%0d]", d), 32'(ofd), 32'(efd));
      chk($sformatf("busy[%0d]", d), 32'(obusy), 32'(ebusy));
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_rd0"}, 32'(rd0), 0);     chk({tag, "_rd1"}, 32'(rd1), 0);
    chk({tag, "_we0"}, 32'(we0), 0);     chk({tag, "_we1"}, 32'(we1), 0);
    chk({tag, "_le0"}, 32'(le0), 0);     chk({tag, "_le1"}, 32'(le1), 0);
    chk({tag, "_fd0"}, 32'(fd0), 0);     chk({tag, "_fd1"}, 32'(fd1), 0);
    chk({tag, "_busy0"}, 32'(busy0), 0); chk({tag, "_busy1"}, 32'(busy1), 0);
  endtask

  // Start a frame and check every cycle until both instances are idle again.
  // start stays high until cycle drop_at when hold is set.
  task automatic run_frame(input bit hold, input int drop_at);
    start = 1'b1;
    n = 0;
    tick();
    while (n <= 28) begin
      if (!hold || n >= drop_at) start = 1'b0;
      check_cycle();
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #12;
    check_quiet("reset");
    chk("reset_addr0", 32'(addr0), 0);
    chk("reset_data0", 32'(d0), 0);
    chk("reset_addr1", 32'(addr1), 0);
    chk("reset_data1", 32'(d1), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // Normal frame (HBLANK=2 and HBLANK=0 side by side).
    run_frame(1'b0, 0);

    // start held high across the frame, including the DONE cycle of the HBLANK=0 unit.
    run_frame(1'b1, 24);

    // abort on the 5th read strobe.
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    while (n <= 5) begin
      check_cycle();
      if (n == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    while (n <= 30) begin
      check_quiet("after_abort");
      tick();
    end

    // abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_quiet("abort_start_idle");
    tick();
    check_quiet("abort_start_idle2");

    // Fresh frame after abort restarts from address 0.
    run_frame(1'b0, 0);

    // Asynchronous reset in the middle of line 2.
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    while (n <= 17) begin
      check_cycle();
      if (n < 17) tick();
      else break;
    end
    #3;
    rst = 1'b1;
    #1;
    check_quiet("async_rst");
    chk("async_rst_addr0", 32'(addr0), 0);
    chk("async_rst_data0", 32'(d0), 0);
    chk("async_rst_addr1", 32'(addr1), 0);
    chk("async_rst_data1", 32'(d1), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_quiet("post_rst");
    tick();

    // Clean full frame after reset.
    run_frame(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
